// File: rtl/div_pkg.sv
// div_pkg: definitions shared by the divider arbiter files.
//   DIV_WIDTH               - operand/quotient width of the shared divider
//   DIV_ARB_TIMEOUT_DEFAULT - default watchdog limit in WAIT
//   div_arb_state_t         - arbiter sequencer states
package div_pkg;

    localparam int DIV_WIDTH               = 10;
    localparam int DIV_ARB_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } div_arb_state_t;

endpackage : div_pkg

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: bundles the requester side and the divider side of the
// divider arbiter.
//   req/req_a/req_b        - request levels and packed operands (requester i at [i*WIDTH +: WIDTH])
//   ack/res_q/res_ov/res_err - one-hot completion pulse and result of the acked job
//   grant_id               - current or last granted requester
//   div_start/div_a/div_b  - command to the divider
//   div_busy/div_valid/div_ov/div_q - divider status and result
// Modports: slave = arbiter view, master = requesters + divider view.
interface div_arbiter_if
    import div_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = DIV_WIDTH
) ();

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       res_q;
    logic                   res_ov;
    logic                   res_err;
    logic [IDX_W-1:0]       grant_id;
    logic                   div_start;
    logic [WIDTH-1:0]       div_a;
    logic [WIDTH-1:0]       div_b;
    logic                   div_busy;
    logic                   div_valid;
    logic                   div_ov;
    logic [WIDTH-1:0]       div_q;

    modport slave (
        input  req, req_a, req_b, div_busy, div_valid, div_ov, div_q,
        output ack, res_q, res_ov, res_err, grant_id, div_start, div_a, div_b
    );

    modport master (
        output req, req_a, req_b, div_busy, div_valid, div_ov, div_q,
        input  ack, res_q, res_ov, res_err, grant_id, div_start, div_a, div_b
    );

endinterface : div_arbiter_if

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder. The first asserted
// request at or after rr_ptr (wrapping modulo N_REQ) wins.
//   req    in  N_REQ  request levels
//   rr_ptr in  IDX_W  index with highest priority
//   grant  out N_REQ  one-hot winner (all zero when req == 0)
//   idx    out IDX_W  index of the winner (0 when req == 0)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/div_arbiter.sv
// div_arbiter: shares one divider among N_REQ requesters. A round-robin
// winner's operands are latched, the divider is started with a one-cycle
// pulse, and the result is returned to the winner with a one-cycle ack.
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   bus      - div_arbiter_if.slave (requester and divider signals)
// Optional build macro DIV_ARB_TIMEOUT_EN: WAIT watchdog that aborts a job
// after TIMEOUT_CYCLES cycles and acks it with res_err = 1.
module div_arbiter
    import div_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = DIV_WIDTH,
    parameter int TIMEOUT_CYCLES = DIV_ARB_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("div_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    div_arb_state_t   state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             seen_busy_q, seen_busy_d;
    logic [WIDTH-1:0] res_q_q, res_q_d;
    logic             res_ov_q, res_ov_d;
`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             res_err_q, res_err_d;
`endif

    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .idx    (pick_idx)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        seen_busy_d = seen_busy_q;
        div_start_d = 1'b0;
        ack_d       = '0;
        res_q_d     = '0;
        res_ov_d    = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        res_err_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if ((|bus.req) && !bus.div_busy) begin
                    // One-hot AND-OR mux of the winner's operands.
                    op_a_d = '0;
                    op_b_d = '0;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_grant[i]) begin
                            op_a_d = op_a_d | bus.req_a[i*WIDTH +: WIDTH];
                            op_b_d = op_b_d | bus.req_b[i*WIDTH +: WIDTH];
                        end
                    end
                    grant_id_d  = pick_idx;
                    div_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                seen_busy_d = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
                wait_cnt_d  = '0;
`endif
                state_d     = WAIT;
            end

            WAIT: begin
                if (bus.div_busy) begin
                    seen_busy_d = 1'b1;
                end
                // A valid before the divider has shown busy belongs to an
                // earlier job and must not complete this one.
                if (seen_busy_q && bus.div_valid) begin
                    res_q_d           = bus.div_q;
                    res_ov_d          = bus.div_ov;
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = RESPOND;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_err_d         = 1'b1;
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = RESPOND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            RESPOND: begin
                rr_ptr_d = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            ack_q       <= '0;
            div_start_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            seen_busy_q <= 1'b0;
            res_q_q     <= '0;
            res_ov_q    <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            ack_q       <= ack_d;
            div_start_q <= div_start_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            seen_busy_q <= seen_busy_d;
            res_q_q     <= res_q_d;
            res_ov_q    <= res_ov_d;
`ifdef DIV_ARB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign bus.ack       = ack_q;
    assign bus.res_q     = res_q_q;
    assign bus.res_ov    = res_ov_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.div_start = div_start_q;
    assign bus.div_a     = op_a_q;
    assign bus.div_b     = op_b_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign bus.res_err   = res_err_q;
`else
    assign bus.res_err   = 1'b0;
`endif

endmodule : div_arbiter

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: self-checking bench for div_arbiter with a behavioural
// divider model, a scoreboard of expected jobs and a table of single jobs.
module tb_div_arbiter;
    import div_pkg::*;

    localparam int N = 4;
    localparam int W = DIV_WIDTH;
`ifdef DIV_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = DIV_ARB_TIMEOUT_DEFAULT;
`endif

    logic clk = 1'b0;
    logic rst;

    div_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    div_arbiter #(
        .N_REQ          (N),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int a; int b; int q; int ov; int err; } job_t;
    typedef struct { int idx; int a; int b; int q; int ov; } vec_t;

    job_t sb[$];
    job_t popped;
    vec_t vecs[8];

    int tests_run    = 0;
    int tests_failed = 0;
    int ack_cnt      = 0;
    bit in_job       = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- divider model ----------------
    logic         m_busy, m_valid, m_ov, m_ovp;
    logic [W-1:0] m_q, m_res;
    int           m_cnt;
    int           div_lat    = 2;
    bit           stale_mode = 1'b0;
    bit           hang_mode  = 1'b0;

    assign bus.div_busy  = m_busy;
    assign bus.div_valid = m_valid;
    assign bus.div_ov    = m_ov;
    assign bus.div_q     = m_q;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_q     <= '0;
            m_ov    <= 1'b0;
            m_ovp   <= 1'b0;
            m_res   <= '0;
            m_cnt   <= 0;
        end else begin
            m_valid <= 1'b0;
            if (bus.div_start) begin
                m_busy <= 1'b1;
                m_cnt  <= div_lat;
                if (bus.div_b == '0) begin
                    m_res <= '1;
                    m_ovp <= 1'b1;
                end else begin
                    m_res <= bus.div_a / bus.div_b;
                    m_ovp <= 1'b0;
                end
                if (stale_mode) begin
                    m_valid <= 1'b1;
                    m_q     <= '1;
                    m_ov    <= 1'b1;
                end
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_busy <= 1'b0;
                    if (!hang_mode) begin
                        m_valid <= 1'b1;
                        m_q     <= m_res;
                        m_ov    <= m_ovp;
                    end
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            in_job <= 1'b0;
        end else begin
            if (bus.div_start) begin
                if (sb.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    check("grant_id", int'(bus.grant_id), sb[0].idx);
                    check("div_a", int'(bus.div_a), sb[0].a);
                    check("div_b", int'(bus.div_b), sb[0].b);
                end
                in_job <= 1'b1;
            end else if (in_job && sb.size() > 0) begin
                check("div_a_hold", int'(bus.div_a), sb[0].a);
                check("div_b_hold", int'(bus.div_b), sb[0].b);
            end
            if (bus.ack != '0) begin
                check("ack_onehot", $countones(bus.ack), 1);
                if (sb.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    popped = sb.pop_front();
                    check("ack_vec", int'(bus.ack), 1 << popped.idx);
                    check("res_q", int'(bus.res_q), popped.q);
                    check("res_ov", int'(bus.res_ov), popped.ov);
                    check("res_err", int'(bus.res_err), popped.err);
                end
                ack_cnt <= ack_cnt + 1;
                in_job  <= 1'b0;
            end else begin
                check("res_idle_zero", int'({bus.res_q, bus.res_ov, bus.res_err}), 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input int i, input int a, input int b);
        bus.req_a[i*W +: W] = W'(a);
        bus.req_b[i*W +: W] = W'(b);
    endtask

    task automatic push(input int i, input int a, input int b, input int q, input int ov, input int err);
        job_t j;
        j.idx = i; j.a = a; j.b = b; j.q = q; j.ov = ov; j.err = err;
        sb.push_back(j);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget);
        int cyc;
        cyc = 0;
        while (!bus.div_start && cyc < budget) begin
            step();
            cyc++;
        end
        check("start_timeout", int'(bus.div_start), 1);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int target;
        int cyc;
        target = ack_cnt + n;
        cyc    = 0;
        while (ack_cnt < target && cyc < budget) begin
            step();
            cyc++;
        end
        check("ack_timeout", int'(ack_cnt >= target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "global timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{1, 1023,  1, 1023, 0};
        vecs[1] = '{2,    7,  0, 1023, 1};
        vecs[2] = '{3,    5,  9,    0, 0};
        vecs[3] = '{1,  100,  5,   20, 0};
        vecs[4] = '{0,    0,  7,    0, 0};
        vecs[5] = '{2,  999, 10,   99, 0};
        vecs[6] = '{0,  512,  2,  256, 0};
        vecs[7] = '{3, 1000, 33,   30, 0};

        rst       = 1'b1;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (3) step();

        // Reset state
        check("rst_ack", int'(bus.ack), 0);
        check("rst_div_start", int'(bus.div_start), 0);
        check("rst_div_a", int'(bus.div_a), 0);
        check("rst_div_b", int'(bus.div_b), 0);
        check("rst_grant_id", int'(bus.grant_id), 0);
        check("rst_res", int'({bus.res_q, bus.res_ov, bus.res_err}), 0);
        rst = 1'b0;
        step();

        // Single request with exact latency: d = div_lat + 1 WAIT cycles.
        set_op(0, 110, 3);
        bus.req[0] = 1'b1;
        push(0, 110, 3, 36, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) begin
                check("lat_start_c1", int'(bus.div_start), 1);
                bus.req[0] = 1'b0;
            end else begin
                check("lat_start_off", int'(bus.div_start), 0);
            end
            check("lat_ack0", int'(bus.ack[0]), (c == 5) ? 1 : 0);
        end

        // Table of single jobs
        foreach (vecs[k]) begin
            set_op(vecs[k].idx, vecs[k].a, vecs[k].b);
            bus.req[vecs[k].idx] = 1'b1;
            push(vecs[k].idx, vecs[k].a, vecs[k].b, vecs[k].q, vecs[k].ov, 0);
            wait_start(20);
            bus.req = '0;
            wait_acks(1, 40);
        end

        // Contention: rr_ptr is 0 after serving requester 3.
        for (int i = 0; i < N; i++) set_op(i, 100, 5);
        push(0, 100, 5, 20, 0, 0);
        push(1, 100, 5, 20, 0, 0);
        push(2, 100, 5, 20, 0, 0);
        push(3, 100, 5, 20, 0, 0);
        push(0, 100, 5, 20, 0, 0);
        bus.req = 4'b1111;
        wait_acks(5, 100);
        bus.req = '0;
        step();

        // Round-robin pointer: serve 2, then 1 and 3 together -> 3 first.
        set_op(2, 60, 4);
        bus.req[2] = 1'b1;
        push(2, 60, 4, 15, 0, 0);
        wait_start(20);
        bus.req = '0;
        wait_acks(1, 40);
        set_op(1, 81, 9);
        set_op(3, 77, 7);
        push(3, 77, 7, 11, 0, 0);
        push(1, 81, 9, 9, 0, 0);
        bus.req = 4'b1010;
        wait_acks(2, 60);
        bus.req = '0;
        step();

        // Stale valid before busy must be ignored.
        stale_mode = 1'b1;
        set_op(0, 50, 7);
        bus.req[0] = 1'b1;
        push(0, 50, 7, 7, 0, 0);
        wait_start(20);
        bus.req = '0;
        wait_acks(1, 40);
        stale_mode = 1'b0;
        step();

        // Reset two cycles after div_start; rr_ptr is 1 before the reset.
        div_lat = 10;
        set_op(1, 200, 3);
        bus.req[1] = 1'b1;
        push(1, 200, 3, 66, 0, 0);
        wait_start(20);
        bus.req = '0;
        step();
        step();
        rst = 1'b1;
        sb.delete();
        step();
        check("wrst_ack", int'(bus.ack), 0);
        check("wrst_div_start", int'(bus.div_start), 0);
        check("wrst_grant_id", int'(bus.grant_id), 0);
        check("wrst_div_a", int'(bus.div_a), 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst_no_start", int'(bus.div_start), 0);
            check("post_rst_no_ack", int'(bus.ack), 0);
        end
        div_lat = 2;
        set_op(0, 90, 9);
        set_op(3, 45, 5);
        push(0, 90, 9, 10, 0, 0);
        push(3, 45, 5, 9, 0, 0);
        bus.req = 4'b1001;
        wait_acks(2, 60);
        bus.req = '0;
        step();

`ifdef DIV_ARB_TIMEOUT_EN
        // Watchdog: divider never reports valid.
        hang_mode = 1'b1;
        div_lat   = 3;
        set_op(2, 33, 3);
        bus.req[2] = 1'b1;
        push(2, 33, 3, 0, 0, 1);
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 1) bus.req = '0;
            check("wd_ack2", int'(bus.ack[2]), (c == 10) ? 1 : 0);
        end
        hang_mode = 1'b0;
        div_lat   = 2;
        repeat (5) step();
`endif

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_div_arbiter

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one `div_top` divider among `N_REQ` requesters. It latches the granted requester's operands and pulses the divider's `start`. It then waits for the divider to finish and returns quotient and overflow to the winner with a one-cycle `ack`. It sits between the requesting datapaths and the single divider instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 10, operand/quotient width; must match divider
- `TIMEOUT_CYCLES`, 64, watchdog limit in WAIT (used only with `DIV_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N_REQ  per-requester request level
- `req_a`  in  N_REQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  N_REQ*WIDTH  divisors, same packing
- `ack`  out  N_REQ  one-hot, one-cycle completion pulse
- `res_q`  out  WIDTH  quotient, valid only while any `ack` bit is high
- `res_ov`  out  1  divider overflow for the acked job
- `res_err`  out  1  watchdog abort flag for the acked job
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester
- `div_start`  out  1  divider start
- `div_a`, `div_b`  out  WIDTH  divider operands
- `div_busy`, `div_valid`, `div_ov`  in  1  divider status
- `div_q`  in  WIDTH  divider quotient

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESPOND.
- **IDLE**: if `req` != 0 and `div_busy` = 0, choose the winner round-robin, starting from `rr_ptr`.
  - Latch the winner's A/B into operand registers.
  - Set `grant_id`, then go to ISSUE.
- **ISSUE**: `div_start` = 1 for exactly this cycle. Clear `seen_busy`, then go to WAIT.
- **WAIT**:
  - `div_start` = 0.
  - Set `seen_busy` when `div_busy` = 1.
  - Completion occurs when `seen_busy` = 1 and `div_valid` = 1. On completion, capture `div_q` and `div_ov`, then go to RESPOND.
  - A `div_valid` seen before `seen_busy` is stale and is ignored.
- **RESPOND**:
  - `ack[grant_id]` = 1 and `res_q`/`res_ov`/`res_err` are driven.
  - `rr_ptr` = `grant_id`+1, wrapping modulo `N_REQ`.
  - Go to IDLE.
- `div_a`/`div_b` are driven from the operand registers, which are held stable from ISSUE through RESPOND.
- Requester inputs are don't-care after the grant.
- A requester may drop `req` after it is granted; its job still completes and is acked.
- `req` must stay high until granted.
- B = 0 is passed through unchanged; the divider's `ov` is forwarded as `res_ov`.
- Outside RESPOND: `ack` = 0, `res_q` = 0, `res_ov` = 0, `res_err` = 0.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `ack` 0, `div_start` 0, `div_a`/`div_b` 0, all `res_*` 0.
- Reset mid-operation aborts immediately. No `ack` is issued. The divider sees no further `start`.
- Request latency for a job taking d WAIT cycles:
  - request seen in IDLE at cycle 0
  - `div_start` at cycle 1
  - WAIT from cycle 2
  - `div_valid` observed at cycle 1+d
  - `ack` at cycle 2+d
  - IDLE again at cycle 3+d
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESPOND. Minimum spacing between two `div_start` pulses is d+3 cycles.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins. Each active requester is served within `N_REQ` grants.
- A request that rises in RESPOND is seen in the following IDLE cycle.

## Configuration
- `DIV_ARB_TIMEOUT_EN` defined:
  - A WAIT cycle counter is enabled.
  - After `TIMEOUT_CYCLES` cycles in WAIT without completion, go to RESPOND with `res_err` = 1 and `res_q` = 0, `res_ov` = 0.
  - `rr_ptr` advances as usual.
- `DIV_ARB_TIMEOUT_EN` undefined:
  - There is no counter.
  - `res_err` is tied to 0.
  - WAIT persists until completion.

## Structure
- Shared package `div_pkg` holds:
  - `DIV_WIDTH` = 10
  - the `div_arb_state_t` enum (IDLE, ISSUE, WAIT, RESPOND)
  - `DIV_ARB_TIMEOUT_DEFAULT` = 64
- One sub-module, `rr_pick`: combinational round-robin priority encoder. Inputs are `req` and `rr_ptr`; outputs are a one-hot grant and an index.

## Test plan
- Single request: req[0] with A=110, B=3 → one `div_start` pulse, then `ack[0]` with `res_q`=36, `res_ov`=0; `div_a`/`div_b` stable until `ack`.
- Contention: `req`=4'b1111 held, all A=100, B=5 → acks in order 0,1,2,3,0, each with `res_q`=20; never two acks in one cycle.
- Round-robin pointer: after serving req[2], raise req[1] and req[3] together → req[3] granted first.
- Divide by zero: A=7, B=0 → `ack` with `res_ov`=1 mirrored from the divider.
- Reset in WAIT: assert `rst` two cycles after `div_start` → next cycle `ack`=0, `div_start`=0, state IDLE; the next request is served normally from `rr_ptr`=0.
- Watchdog (with `DIV_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): divider model never raises `div_valid` → `ack` with `res_err`=1 and `res_q`=0, 8 cycles after WAIT entry.
